perif_uart_tx_fifo: RTL and testbench

// - Parametrised UART transmitter with a true circular TX FIFO. It is the successor to the fixed 8N1 / 4-entry TX.
// - Sits in the UART peripheral between the bus register file (write port) and the pad o_uart_tx.
// - Runtime-configurable frame: 5-8 data bits, 1 or 2 stop bits, optional parity.
// - Adds empty/full/level/overflow status and back-to-back frames with no idle gap.

---
 rtl/perif_uart_pkg.sv | 13 +
 rtl/perif_sync_fifo.sv | 41 ++++
 rtl/perif_uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_perif_uart_tx_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/perif_uart_pkg.sv
// perif_uart_pkg: shared UART types, frame encodings and line constants
package perif_uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_tx_state_e;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2} parity_e;
  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  function automatic logic [2:0] last_bit(input logic [1:0] db);
    return 3'(db) + 3'd4;
  endfunction
endpackage

// File: rtl/perif_sync_fifo.sv
// perif_sync_fifo: circular synchronous FIFO with full/empty/level, shared by TX and RX paths
module perif_sync_fifo #(
  parameter int P_WIDTH = 8,
  parameter int P_DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [P_WIDTH-1:0]         i_data,
  output logic [P_WIDTH-1:0]         o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(P_DEPTH):0]   o_level
);
  localparam int AW = $clog2(P_DEPTH);
  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop;
  assign push = i_push && !o_full;
  assign pop = i_pop && !o_empty;
  assign o_full = cnt == (AW+1)'(P_DEPTH);
  assign o_empty = cnt == '0;
  assign o_level = cnt;
  assign o_data = mem[rp];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= i_data;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/perif_uart_tx_fifo.sv
// perif_uart_tx_fifo: configurable UART transmitter fed by a circular TX FIFO
// Parity support is compiled in only when PERIF_UART_TX_PARITY_EN is defined.
module perif_uart_tx_fifo import perif_uart_pkg::*; #(
  parameter int P_FIFO_DEPTH = 8,
  parameter int P_BAUD_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_data_tx,
  input  logic [P_BAUD_W-1:0]           i_baudrate,
  input  logic [1:0]                    i_data_bits,
  input  logic                          i_stop2,
  input  logic [1:0]                    i_parity,
  output logic                          o_tx_full,
  output logic                          o_tx_empty,
  output logic [$clog2(P_FIFO_DEPTH):0] o_tx_level,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic                          o_uart_tx
);
  uart_tx_state_e st;
  logic [7:0] head, sh, md;
  logic [2:0] nb, bitn;
  logic [P_BAUD_W-1:0] cnt, bd;
  logic stop2, has_par, pbit, par_en, pb, bnd, fin, ld, tx, ovf;
  perif_sync_fifo #(.P_WIDTH(8), .P_DEPTH(P_FIFO_DEPTH)) u_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_push(i_wr_en),
    .i_pop(ld),
    .i_data(i_data_tx),
    .o_data(head),
    .o_full(o_tx_full),
    .o_empty(o_tx_empty),
    .o_level(o_tx_level)
  );
`ifdef PERIF_UART_TX_PARITY_EN
  assign par_en = i_parity == PAR_ODD || i_parity == PAR_EVEN;
`else
  assign par_en = 1'b0;
`endif
  // parity is precomputed from the head byte when it is loaded
  assign md = head & (8'hFF >> (DB_8 - i_data_bits));
  assign pb = i_parity == PAR_ODD ? ~^md : ^md;
  assign bnd = cnt == bd;
  assign fin = st == ST_STOP && bnd && (!stop2 || bitn == 3'd1);
  assign ld = i_en && !o_tx_empty && (st == ST_IDLE || fin);
  assign o_busy = st != ST_IDLE;
  assign o_uart_tx = tx;
  assign o_overflow = ovf;
  always_ff @(posedge i_clk) begin
    if (i_rst) ovf <= 1'b0;
    else if (i_wr_en && o_tx_full) ovf <= 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      st <= ST_IDLE;
      tx <= UART_IDLE_LEVEL;
      cnt <= '0;
      bitn <= '0;
    end else if (ld) begin
      st <= ST_START;
      tx <= 1'b0;
      cnt <= '0;
      bd <= i_baudrate;
      bitn <= '0;
      sh <= head;
      nb <= last_bit(i_data_bits);
      stop2 <= i_stop2;
      has_par <= par_en;
      pbit <= pb;
    end else if (st != ST_IDLE) begin
      if (!bnd) cnt <= cnt + P_BAUD_W'(1);
      else begin
        cnt <= '0;
        bd <= i_baudrate;
        case (st)
          ST_START: begin
            st <= ST_DATA;
            tx <= sh[0];
            sh <= sh >> 1;
            bitn <= '0;
          end
          ST_DATA: begin
            if (bitn == nb) begin
              st <= has_par ? ST_PARITY : ST_STOP;
              tx <= has_par ? pbit : UART_IDLE_LEVEL;
              bitn <= '0;
            end else begin
              tx <= sh[0];
              sh <= sh >> 1;
              bitn <= bitn + 3'd1;
            end
          end
          ST_PARITY: begin
            st <= ST_STOP;
            tx <= UART_IDLE_LEVEL;
            bitn <= '0;
          end
          ST_STOP: begin
            st <= fin ? ST_IDLE : ST_STOP;
            bitn <= 3'd1;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_perif_uart_tx_fifo.sv
// tb_perif_uart_tx_fifo: frame vectors, corner sequences and random traffic against a queue-based line model
module tb_perif_uart_tx_fifo;
  localparam int D = 8;
  logic clk = 0, rst = 1, en = 0, wr = 0, stop2 = 0;
  logic [7:0] data = 0;
  logic [15:0] baud = 0;
  logic [1:0] dbits = 3, par = 0;
  logic full, empty, busy, ovf, tx;
  logic [3:0] level;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic pend[$];
  logic m_tx = 1, m_busy = 0, m_ovf = 0;

  typedef struct {logic [7:0] d; logic [1:0] db; logic s2; logic [1:0] p; logic [15:0] b; string exp;} vec_t;
  vec_t vt[4];

  perif_uart_tx_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_wr_en(wr), .i_data_tx(data), .i_baudrate(baud),
    .i_data_bits(dbits), .i_stop2(stop2), .i_parity(par), .o_tx_full(full), .o_tx_empty(empty),
    .o_tx_level(level), .o_busy(busy), .o_overflow(ovf), .o_uart_tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic expand(input logic [7:0] d);
    logic b[$];
    int nb;
    nb = int'(dbits) + 5;
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(d[i]);
`ifdef PERIF_UART_TX_PARITY_EN
    if (par == 2'd1 || par == 2'd2) begin
      int ones;
      ones = $countones(d & (8'hFF >> (8 - nb)));
      b.push_back(par == 2'd1 ? (ones % 2 == 0) : (ones % 2 == 1));
    end
`endif
    repeat (stop2 ? 2 : 1) b.push_back(1'b1);
    foreach (b[i]) repeat (int'(baud) + 1) pend.push_back(b[i]);
  endtask

  task automatic model();
    logic full_pre;
    if (rst) begin
      q.delete(); pend.delete(); m_tx = 1; m_busy = 0; m_ovf = 0;
    end else begin
      full_pre = q.size() == D;
      if (!en) begin
        pend.delete(); m_tx = 1; m_busy = 0;
      end else begin
        if (pend.size() == 0 && q.size() > 0) expand(q.pop_front());
        m_busy = pend.size() > 0;
        m_tx = m_busy ? pend.pop_front() : 1'b1;
      end
      if (wr) begin
        if (full_pre) m_ovf = 1;
        else q.push_back(data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("tx", 32'(tx), 32'(m_tx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic drain();
    int n;
    en = 1; wr = 0; n = 0;
    while ((m_busy || q.size() > 0) && n < 3000) begin tick(); n++; end
    tick();
    chk("drain_timeout", 32'(n < 3000), 32'(1));
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1; data = d; tick(); wr = 0;
  endtask

  initial begin
    vt[0] = '{8'hA5, 2'd3, 1'b0, 2'd0, 16'd3, "0101001011"};
`ifdef PERIF_UART_TX_PARITY_EN
    vt[1] = '{8'h83, 2'd2, 1'b1, 2'd2, 16'd1, "01100000011"};
    vt[2] = '{8'h1F, 2'd0, 1'b0, 2'd1, 16'd0, "01111101"};
`else
    vt[1] = '{8'h83, 2'd2, 1'b1, 2'd2, 16'd1, "0110000011"};
    vt[2] = '{8'h1F, 2'd0, 1'b0, 2'd1, 16'd0, "0111111"};
`endif
    vt[3] = '{8'h3C, 2'd1, 1'b1, 2'd3, 16'd2, "000111111"};
    tick(); tick();
    chk("rst_tx", 32'(tx), 1); chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(empty), 1); chk("rst_ovf", 32'(ovf), 0);
    rst = 0; en = 1; tick();
    foreach (vt[v]) begin
      dbits = vt[v].db; stop2 = vt[v].s2; par = vt[v].p; baud = vt[v].b;
      push(vt[v].d);
      for (int c = 0; c < vt[v].exp.len() * (int'(baud) + 1); c++) begin
        tick();
        chk("frame_bit", 32'(tx), 32'(vt[v].exp[c / (int'(baud) + 1)] == "1"));
        chk("frame_busy", 32'(busy), 1);
      end
      tick();
      chk("frame_end_busy", 32'(busy), 0);
      chk("frame_end_tx", 32'(tx), 1);
    end
    dbits = 3; stop2 = 0; par = 0; baud = 0;
    drain();
    en = 0;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    chk("lvl6", 32'(level), 6);
    en = 1; tick();
    chk("lvl5_start", 32'(level), 5);
    repeat (9) tick();
    chk("lvl5_pre", 32'(level), 5);
    push(8'h5A);
    chk("lvl_pushpop", 32'(level), 5);
    chk("b2b_start", 32'(tx), 0);
    drain();
    en = 0;
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    chk("burst_full", 32'(full), 1); chk("burst_level", 32'(level), 8); chk("burst_ovf", 32'(ovf), 1);
    begin
      int bc;
      bc = 0;
      en = 1;
      for (int i = 0; i < 80; i++) begin tick(); bc += int'(busy); end
      chk("burst_no_gap", 32'(bc), 80);
      tick();
      chk("burst_empty", 32'(empty), 1); chk("burst_idle", 32'(busy), 0);
    end
    baud = 3; en = 0;
    push(8'hFF); push(8'h12); push(8'h34);
    en = 1; tick();
    repeat (17) tick();
    chk("abort_pre", 32'(tx), 1);
    en = 0; tick();
    chk("abort_tx", 32'(tx), 1); chk("abort_busy", 32'(busy), 0); chk("abort_level", 32'(level), 2);
    en = 1; tick();
    chk("resume_start", 32'(tx), 0); chk("resume_level", 32'(level), 1);
    drain();
    for (int r = 0; r < 25; r++) begin
      dbits = 2'($urandom_range(0, 3)); stop2 = 1'($urandom_range(0, 1));
      par = 2'($urandom_range(0, 3)); baud = 16'($urandom_range(0, 2));
      for (int c = 0; c < 60; c++) begin
        en = $urandom_range(0, 40) != 0;
        wr = $urandom_range(0, 3) == 0;
        data = 8'($urandom);
        tick();
      end
      drain();
    end
    dbits = 3; stop2 = 0; par = 0; baud = 3;
    push(8'h96); push(8'h69);
    begin
      int n;
      n = 0;
      while (!(m_busy && pend.size() == 2) && n < 200) begin tick(); n++; end
      chk("stop_wait_timeout", 32'(n < 200), 1);
      chk("mid_stop_tx", 32'(tx), 1);
    end
    rst = 1; tick();
    chk("rst_stop_tx", 32'(tx), 1); chk("rst_stop_empty", 32'(empty), 1);
    chk("rst_stop_busy", 32'(busy), 0); chk("rst_stop_ovf", 32'(ovf), 0);
    rst = 0; tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
